// File: rtl/alu_execute_stage.sv
// Sequential execute stage in front of the combinational ArithmeticUnit.
// It registers an opcode and two operands, drives them to the unit, waits
// SETTLE_CYCLES cycles, then captures the unit's result and derives the
// Z/N/C/V status flags for write-back and branch logic.
//
// Handshake: start is sampled on a rising edge only while the stage is idle
// or in its done cycle; busy is high for every cycle the request is
// executing; done is a single-cycle pulse, and result_out plus the flags are
// valid from that cycle until the next capture.
module alu_execute_stage #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode_in,
  input  logic [WIDTH-1:0] operand_a_in,
  input  logic [WIDTH-1:0] operand_b_in,
  output logic [2:0]       au_opcode,
  output logic [WIDTH-1:0] au_operand_a,
  output logic [WIDTH-1:0] au_operand_b,
  input  logic [WIDTH-1:0] au_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic             flag_zero,
  output logic             flag_negative,
  output logic             flag_carry,
  output logic             flag_overflow,
  output logic [1:0]       debugState
);

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXECUTE = 2'd1,
    DONE    = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;
  logic [3:0] settleCount;
  logic acceptReq;
  logic captureNow;

  logic isAdd;
  logic isSub;
  logic [WIDTH-1:0] bEffective;
  logic [WIDTH:0] sumWide;
  logic carryNext;
  logic overflowNext;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode plus the accept and capture strobes.
  always_comb begin
    stateNext  = state;
    acceptReq  = 1'b0;
    captureNow = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acceptReq = 1'b1;
          stateNext = EXECUTE;
        end
      end
      EXECUTE: begin
        if (settleCount == 4'd0) begin
          captureNow = 1'b1;
          stateNext  = DONE;
        end
      end
      DONE: begin
        if (start) begin
          acceptReq = 1'b1;
          stateNext = EXECUTE;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy       = (state == EXECUTE);
  assign done       = (state == DONE);
  assign debugState = state;

  // Settle counter: loaded on accept, counts down while executing.
  always_ff @(posedge clock) begin
    if (reset) begin
      settleCount <= 4'd0;
    end else if (acceptReq) begin
      settleCount <= SETTLE_LOAD;
    end else if (state == EXECUTE && settleCount != 4'd0) begin
      settleCount <= settleCount - 4'd1;
    end
  end

  // Carry and overflow come from a private WIDTH+1 bit add of the registered
  // operands; SUB is done as A + ~B + 1 so carry reads as no-borrow.
  always_comb begin
    isAdd        = (au_opcode == OP_ADD);
    isSub        = (au_opcode == OP_SUB);
    bEffective   = isSub ? ~au_operand_b : au_operand_b;
    sumWide      = {1'b0, au_operand_a} + {1'b0, bEffective}
                 + {{WIDTH{1'b0}}, isSub};
    carryNext    = (isAdd | isSub) & sumWide[WIDTH];
    overflowNext = (isAdd | isSub)
                 & (au_operand_a[WIDTH-1] == bEffective[WIDTH-1])
                 & (sumWide[WIDTH-1] != au_operand_a[WIDTH-1]);
  end

  // Request registers toward the unit and the captured result/flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      au_opcode     <= 3'd0;
      au_operand_a  <= '0;
      au_operand_b  <= '0;
      result_out    <= '0;
      flag_zero     <= 1'b0;
      flag_negative <= 1'b0;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
    end else begin
      if (acceptReq) begin
        au_opcode    <= opcode_in;
        au_operand_a <= operand_a_in;
        au_operand_b <= operand_b_in;
      end
      if (captureNow) begin
        result_out    <= au_result;
        flag_zero     <= (au_result == '0);
        flag_negative <= au_result[WIDTH-1];
        flag_carry    <= carryNext;
        flag_overflow <= overflowNext;
      end
    end
  end

endmodule
